// File: rtl/hdc_pkg.sv
// hdc_pkg: shared labels, sizing helpers and FSM state type for the HDC classifier
package hdc_pkg;
   localparam logic LABEL_NONSEIZURE = 1'b0;
   localparam logic LABEL_SEIZURE = 1'b1;
   localparam int HV_DIMENSIONS = 10000;
   function automatic int dist_width(input int d);
      return $clog2(d + 1);
   endfunction
   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} am_state_t;
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: combinational balanced adder-tree popcount of a CHUNK-bit slice
module popcount_chunk #(
   parameter int CHUNK = 500,
   localparam int CNT_W = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] bits,
   output logic [CNT_W-1:0] cnt
);
   localparam int L = $clog2(CHUNK);
   localparam int P = 1 << L;
   // leaves padded with zeros up to a power of two so every level halves cleanly
   for (genvar l = 0; l <= L; l++) begin : g_lvl
      logic [CNT_W-1:0] s [P >> l];
      for (genvar i = 0; i < (P >> l); i++) begin : g_n
         if (l == 0) begin : g_leaf
            if (i < CHUNK) begin : g_b
               assign s[i] = CNT_W'(bits[i]);
            end else begin : g_z
               assign s[i] = '0;
            end
         end else begin : g_add
            assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
         end
      end
   end
   assign cnt = g_lvl[L].s[0];
endmodule

// File: rtl/assoc_mem_hamming.sv
// assoc_mem_hamming: chunked Hamming-distance classifier of a query HV against
// the non-seizure and seizure class prototypes, with registered results.
module assoc_mem_hamming
   import hdc_pkg::*;
#(
   parameter int DIMENSIONS = HV_DIMENSIONS,
   parameter int CHUNK = 500,
   localparam int NCHUNK = DIMENSIONS / CHUNK,
   localparam int DIST_W = dist_width(DIMENSIONS)
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic [DIMENSIONS-1:0] hv_query,
   input  logic [DIMENSIONS-1:0] hv_nonseizure,
   input  logic [DIMENSIONS-1:0] hv_seizure,
   output logic busy,
   output logic done,
   output logic label,
   output logic [DIST_W-1:0] dist_nonseizure,
   output logic [DIST_W-1:0] dist_seizure
);
   localparam int PC_W = $clog2(CHUNK + 1);
   localparam int K_W = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   if (DIMENSIONS % CHUNK != 0) begin : g_chk
      $fatal(1, "assoc_mem_hamming: DIMENSIONS must be a multiple of CHUNK");
   end
   am_state_t state;
   logic [DIMENSIONS-1:0] x_n, x_s;
   logic [DIST_W-1:0] acc_n, acc_s;
   logic [K_W-1:0] k;
   logic [PC_W-1:0] pc_n, pc_s;
   // the XOR registers shift down one chunk per cycle, so the popcounters
   // always see the low slice instead of a wide chunk-select mux
   popcount_chunk #(.CHUNK(CHUNK)) u_pc_n (.bits(x_n[CHUNK-1:0]), .cnt(pc_n));
   popcount_chunk #(.CHUNK(CHUNK)) u_pc_s (.bits(x_s[CHUNK-1:0]), .cnt(pc_s));
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         label <= LABEL_NONSEIZURE;
         dist_nonseizure <= '0;
         dist_seizure <= '0;
         x_n <= '0;
         x_s <= '0;
         acc_n <= '0;
         acc_s <= '0;
         k <= '0;
      end else begin
         case (state)
            IDLE: if (en) begin
               state <= LOAD;
               busy <= 1'b1;
               x_n <= hv_query ^ hv_nonseizure;
               x_s <= hv_query ^ hv_seizure;
               acc_n <= '0;
               acc_s <= '0;
               k <= '0;
            end
            LOAD: state <= COMPUTE;
            COMPUTE: begin
               acc_n <= acc_n + DIST_W'(pc_n);
               acc_s <= acc_s + DIST_W'(pc_s);
               x_n <= x_n >> CHUNK;
               x_s <= x_s >> CHUNK;
               k <= k + 1'b1;
               if (k == K_W'(NCHUNK - 1)) state <= DONE;
            end
            DONE: if (!done) begin
               dist_nonseizure <= acc_n;
               dist_seizure <= acc_s;
               label <= (acc_s < acc_n) ? LABEL_SEIZURE : LABEL_NONSEIZURE;
               done <= 1'b1;
            end else begin
               done <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_assoc_mem_hamming.sv
// tb_assoc_mem_hamming: table-driven and scoreboard checks of the Hamming classifier
// at default size and at a small 16/4 configuration.
module tb_assoc_mem_hamming;
   localparam int D = 10000, DW = 14, SD = 16, SDW = 5;
   logic clk = 0, nrst = 1, en = 0, sen = 0;
   logic [D-1:0] q = '0, hn = '0, hs = '0;
   logic [SD-1:0] sq = '0, sn = '0, ss = '0;
   logic busy, done, label, sbusy, sdone, slabel;
   logic [DW-1:0] dn, ds;
   logic [SDW-1:0] sdn, sds;
   int checks = 0, errors = 0, dones = 0;
   typedef struct {
      logic [D-1:0] q, n, s;
      int dn, ds;
      logic lb;
      string nm;
   } vec_t;
   typedef struct {
      int dn, ds;
      logic lb;
   } exp_t;
   vec_t tbl[4];
   exp_t sb[$];
   assoc_mem_hamming dut (
      .clk(clk), .nrst(nrst), .en(en), .hv_query(q), .hv_nonseizure(hn), .hv_seizure(hs),
      .busy(busy), .done(done), .label(label), .dist_nonseizure(dn), .dist_seizure(ds)
   );
   assoc_mem_hamming #(.DIMENSIONS(SD), .CHUNK(4)) dut_s (
      .clk(clk), .nrst(nrst), .en(sen), .hv_query(sq), .hv_nonseizure(sn), .hv_seizure(ss),
      .busy(sbusy), .done(sdone), .label(slabel), .dist_nonseizure(sdn), .dist_seizure(sds)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (done) dones++;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask
   function automatic logic [D-1:0] ones_at(input int st, input int cnt);
      logic [D-1:0] v = '0;
      for (int i = 0; i < cnt; i++) v[st+i] = 1'b1;
      return v;
   endfunction
   task automatic classify(input string nm, input logic [D-1:0] vq, vn, vs,
                           input int edn, eds, input logic elb, input bit perturb);
      int lat;
      @(negedge clk);
      q = vq; hn = vn; hs = vs; en = 1;
      @(posedge clk);
      #1 en = 0;
      chk({nm, " busy after start"}, int'(busy), 1);
      lat = 0;
      while (!done && lat < 100) begin
         en = (perturb && lat >= 3 && lat <= 18) ? lat[0] : 1'b0;
         if (perturb && lat >= 3 && lat <= 18) begin
            q = ~q; hn = ~hn; hs = ~hs;
         end
         @(posedge clk);
         #1 lat++;
      end
      en = 0;
      chk({nm, " latency"}, lat, 22);
      chk({nm, " dist_nonseizure"}, int'(dn), edn);
      chk({nm, " dist_seizure"}, int'(ds), eds);
      chk({nm, " label"}, int'(label), int'(elb));
      @(posedge clk);
      #1 chk({nm, " done one cycle"}, int'(done), 0);
      chk({nm, " busy released"}, int'(busy), 0);
      chk({nm, " outputs held"}, int'(dn), edn);
   endtask
   initial begin
      logic [D-1:0] r;
      int d0, lat;
      exp_t e;
      for (int i = 0; i < D; i++) r[i] = 1'($urandom_range(1, 0));
      tbl[0] = '{r, ~r, r, 10000, 0, 1'b1, "exact"};
      tbl[1] = '{'0, '0, '1, 0, 10000, 1'b0, "extremes"};
      tbl[2] = '{'0, ones_at(0, 37), ones_at(100, 37), 37, 37, 1'b0, "tie"};
      tbl[3] = '{'0, ones_at(0, 37), ones_at(200, 36), 37, 36, 1'b1, "near tie"};
      #2 nrst = 0;
      #1 chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset label", int'(label), 0);
      chk("reset dist_n", int'(dn), 0);
      chk("reset dist_s", int'(ds), 0);
      chk("reset small busy", int'(sbusy), 0);
      chk("reset small dist_s", int'(sds), 0);
      repeat (2) @(negedge clk);
      nrst = 1;
      for (int t = 0; t < 4; t++)
         classify(tbl[t].nm, tbl[t].q, tbl[t].n, tbl[t].s, tbl[t].dn, tbl[t].ds, tbl[t].lb, 1'b0);
      // isolation: inputs flip and en toggles while busy
      d0 = dones;
      classify("isolation", '0, '1, '0, 10000, 0, 1'b1, 1'b1);
      repeat (30) @(posedge clk);
      #1 chk("isolation single done", dones - d0, 1);
      chk("isolation idle", int'(busy), 0);
      // reset during chunk 10 of COMPUTE
      @(negedge clk);
      q = '0; hn = '0; hs = '1; en = 1;
      @(posedge clk);
      #1 en = 0;
      repeat (11) @(posedge clk);
      #1 nrst = 0;
      d0 = dones;
      #1 chk("midreset busy", int'(busy), 0);
      chk("midreset done", int'(done), 0);
      chk("midreset label", int'(label), 0);
      chk("midreset dist_n", int'(dn), 0);
      chk("midreset dist_s", int'(ds), 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("midreset no done", dones - d0, 0);
      nrst = 1;
      classify("post reset", '0, ones_at(5, 100), ones_at(9000, 250), 100, 250, 1'b0, 1'b0);
      // small configuration: scoreboard against $countones reference
      for (int it = 0; it < 1000; it++) begin
         @(negedge clk);
         sq = SD'($urandom); sn = SD'($urandom); ss = SD'($urandom);
         if (it == 0) begin sq = '0; sn = '0; ss = '0; end
         sb.push_back('{$countones(sq ^ sn), $countones(sq ^ ss), $countones(sq ^ ss) < $countones(sq ^ sn)});
         sen = 1;
         @(posedge clk);
         #1 sen = 0;
         lat = 0;
         while (!sdone && lat < 20) begin
            @(posedge clk);
            #1 lat++;
         end
         e = sb.pop_front();
         chk("small latency", lat, 6);
         chk("small dist_n", int'(sdn), e.dn);
         chk("small dist_s", int'(sds), e.ds);
         chk("small label", int'(slabel), int'(e.lb));
         @(posedge clk);
      end
      // en held high restarts on the first IDLE edge: done-to-done spacing 8
      @(negedge clk);
      sen = 1;
      lat = 0;
      while (!sdone && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      lat = 0;
      @(posedge clk);
      #1 lat++;
      while (!sdone && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      sen = 0;
      chk("small held-en spacing", lat, 8);
      repeat (12) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
